// File: rtl/mem_block_mover_pkg.sv
// Shared types for the block mover: FSM state encoding and operation mode.
package mem_block_mover_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StCap  = 3'd2,
        StWr   = 3'd3,
        StDone = 3'd4
    } state_e;

    typedef enum logic {
        ModeCopy = 1'b0,
        ModeFill = 1'b1
    } mode_e;

endpackage

// File: rtl/mem_block_mover.sv
// Block copy / fill engine driving a single-port synchronous RAM with 1-cycle read latency.
// All memory-side outputs are registered and change only on clock edges.
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_SIZE-1:0] src,
    input  logic [ADDR_SIZE-1:0] dst,
    input  logic [ADDR_SIZE-1:0] len,
    input  logic [WIDTH-1:0]     fill_val,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_cs,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_din,
    input  logic [WIDTH-1:0]     mem_dout
);

    localparam logic [ADDR_SIZE-1:0] AddrOne = ADDR_SIZE'(1);

    state_e                 state_q;
    mode_e                  mode_q;
    logic [ADDR_SIZE-1:0]   src_ptr_q;
    logic [ADDR_SIZE-1:0]   dst_ptr_q;
    logic [ADDR_SIZE-1:0]   remaining_q;
    logic [WIDTH-1:0]       fill_q;

    // mem_din doubles as the copy data register: it is loaded from mem_dout in CAP so the
    // following WR cycle already presents the captured word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mode_q      <= ModeCopy;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_cs      <= 1'b0;
            mem_wen     <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q      <= mode_e'(mode);
                        src_ptr_q   <= src;
                        dst_ptr_q   <= dst;
                        remaining_q <= len;
                        fill_q      <= fill_val;
                        if (len == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else if (mode_e'(mode) == ModeCopy) begin
                            state_q  <= StRd;
                            busy     <= 1'b1;
                            mem_cs   <= 1'b1;
                            mem_wen  <= 1'b0;
                            mem_addr <= src;
                        end else begin
                            state_q  <= StWr;
                            busy     <= 1'b1;
                            mem_cs   <= 1'b1;
                            mem_wen  <= 1'b1;
                            mem_addr <= dst;
                            mem_din  <= fill_val;
                        end
                    end
                end

                StRd: begin
                    state_q <= StCap;
                    mem_cs  <= 1'b0;
                    mem_wen <= 1'b0;
                end

                StCap: begin
                    state_q  <= StWr;
                    mem_cs   <= 1'b1;
                    mem_wen  <= 1'b1;
                    mem_addr <= dst_ptr_q;
                    mem_din  <= mem_dout;
                end

                StWr: begin
                    src_ptr_q   <= src_ptr_q + AddrOne;
                    dst_ptr_q   <= dst_ptr_q + AddrOne;
                    remaining_q <= remaining_q - AddrOne;
                    if (remaining_q == AddrOne) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        mem_cs  <= 1'b0;
                        mem_wen <= 1'b0;
                    end else if (mode_q == ModeCopy) begin
                        state_q  <= StRd;
                        mem_cs   <= 1'b1;
                        mem_wen  <= 1'b0;
                        mem_addr <= src_ptr_q + AddrOne;
                    end else begin
                        state_q  <= StWr;
                        mem_cs   <= 1'b1;
                        mem_wen  <= 1'b1;
                        mem_addr <= dst_ptr_q + AddrOne;
                        mem_din  <= fill_q;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    mem_cs  <= 1'b0;
                    mem_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Randomized self-checking bench for mem_block_mover with a behavioural RAM and a reference model.
module tb_mem_block_mover;

    localparam int W     = 8;
    localparam int A     = 10;
    localparam int DEPTH = 1 << A;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic [A-1:0] src, dst, len;
    logic [W-1:0] fill_val;
    logic         busy, done, mem_cs, mem_wen;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_din, mem_dout;

    mem_block_mover #(.WIDTH(W), .ADDR_SIZE(A)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .mem_cs   (mem_cs),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ram     [DEPTH];
    logic [W-1:0] exp_mem [DEPTH];
    logic [W-1:0] wdata   [DEPTH];

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wen) ram[mem_addr] <= mem_din;
            else         mem_dout      <= ram[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    int done_cycle, done_count, proto_err, first_bad, cs_count;

    task automatic preload_random();
        for (int i = 0; i < DEPTH; i++) ram[i] <= W'($urandom);
        @(negedge clk);
    endtask

    // Reference: words are moved one at a time, lowest first, so overlap propagates naturally.
    task automatic build_model(input logic m, input logic [A-1:0] s, input logic [A-1:0] d,
                               input logic [A-1:0] l, input logic [W-1:0] f);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = ram[i];
        for (int i = 0; i < int'(l); i++) begin
            logic [A-1:0] ra, wa;
            logic [W-1:0] v;
            ra = s + A'(i);
            wa = d + A'(i);
            v = m ? f : exp_mem[ra];
            wdata[i] = v;
            exp_mem[wa] = v;
        end
    endtask

    function automatic int mem_diffs();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) bad++;
        return bad;
    endfunction

    // Launches one operation and watches every cycle against the expected bus schedule.
    task automatic run_op(input logic m, input logic [A-1:0] s, input logic [A-1:0] d,
                          input logic [A-1:0] l, input logic [W-1:0] f, input bit glitch);
        int exp_done;
        build_model(m, s, d, l, f);
        exp_done = (l == 0) ? 1 : (m ? int'(l) + 1 : 3 * int'(l) + 1);
        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
        @(posedge clk);
        done_cycle = -1; done_count = 0; proto_err = 0; first_bad = -1; cs_count = 0;
        for (int n = 1; n <= exp_done + 4; n++) begin
            logic e_busy, e_done, e_cs, e_wen;
            logic [A-1:0] e_addr;
            logic [W-1:0] e_din;
            bit bad;
            @(negedge clk);
            start    = glitch && (n < exp_done);
            mode     = 1'($urandom);
            src      = A'($urandom);
            dst      = A'($urandom);
            len      = A'($urandom);
            fill_val = W'($urandom);
            e_busy = 0; e_done = (n == exp_done); e_cs = 0; e_wen = 0; e_addr = '0; e_din = '0;
            if (l != 0 && n < exp_done) begin
                e_busy = 1;
                if (m) begin
                    e_cs = 1; e_wen = 1; e_addr = d + A'(n - 1); e_din = f;
                end else begin
                    int i, ph;
                    i  = (n - 1) / 3;
                    ph = (n - 1) % 3;
                    if (ph == 0) begin
                        e_cs = 1; e_addr = s + A'(i);
                    end else if (ph == 2) begin
                        e_cs = 1; e_wen = 1; e_addr = d + A'(i); e_din = wdata[i];
                    end
                end
            end
            bad = (busy !== e_busy) || (done !== e_done) || (mem_cs !== e_cs) ||
                  (mem_wen !== e_wen) || (e_cs && mem_addr !== e_addr) ||
                  (e_wen && mem_din !== e_din);
            if (bad) begin
                proto_err++;
                if (first_bad < 0) first_bad = n;
            end
            if (done === 1'b1) begin
                done_count++;
                if (done_cycle < 0) done_cycle = n;
            end
            if (mem_cs === 1'b1) cs_count++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; mode = 1'b0;
        src = 10'h010; dst = 10'h020; len = 10'd5; fill_val = 8'hFF;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({busy, done, mem_cs, mem_wen} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: busy/done/cs/wen = %b, required 0000",
                     {busy, done, mem_cs, mem_wen});
        end
        n_cmp++;
        if (mem_addr !== '0 || mem_din !== '0) begin
            n_err++;
            $display("FAIL reset_bus: addr=%h din=%h, required 0/0", mem_addr, mem_din);
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        begin
            int act = 0;
            repeat (5) begin
                @(negedge clk);
                if (busy || done || mem_cs) act++;
            end
            n_cmp++;
            if (act != 0) begin
                n_err++;
                $display("FAIL reset_idle: %0d active cycles after release, required 0", act);
            end
        end
    endtask

    task automatic test_copy_basic();
        logic [W-1:0] pat [4];
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
        preload_random();
        for (int i = 0; i < 4; i++) ram[10'h010 + i] <= pat[i];
        @(negedge clk);
        run_op(1'b0, 10'h010, 10'h080, 10'd4, 8'h00, 1'b0);
        n_cmp++;
        if (done_cycle != 13 || done_count != 1) begin
            n_err++;
            $display("FAIL copy_done: cycle %0d count %0d, required cycle 13 count 1",
                     done_cycle, done_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ram[10'h080 + i] !== pat[i] || ram[10'h010 + i] !== pat[i]) begin
                n_err++;
                $display("FAIL copy_word%0d: dst=%h src=%h, required %h", i,
                         ram[10'h080 + i], ram[10'h010 + i], pat[i]);
            end
        end
        n_cmp++;
        if (proto_err != 0) begin
            n_err++;
            $display("FAIL copy_bus: %0d bad cycles (first %0d), required 0", proto_err, first_bad);
        end
    endtask

    task automatic test_fill_wrap();
        logic [A-1:0] addrs [4];
        addrs[0] = 10'h3FE; addrs[1] = 10'h3FF; addrs[2] = 10'h000; addrs[3] = 10'h001;
        preload_random();
        ram[10'h002] <= 8'h00; ram[10'h3FD] <= 8'h00;
        @(negedge clk);
        run_op(1'b1, 10'h000, 10'h3FE, 10'd4, 8'h5A, 1'b0);
        n_cmp++;
        if (done_cycle != 5 || done_count != 1) begin
            n_err++;
            $display("FAIL fill_done: cycle %0d count %0d, required cycle 5 count 1",
                     done_cycle, done_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ram[addrs[i]] !== 8'h5A) begin
                n_err++;
                $display("FAIL fill_wrap%0d: mem[%h]=%h, required 5a", i, addrs[i], ram[addrs[i]]);
            end
        end
        n_cmp++;
        if (ram[10'h002] !== 8'h00 || ram[10'h3FD] !== 8'h00) begin
            n_err++;
            $display("FAIL fill_bounds: mem[002]=%h mem[3fd]=%h, required 00/00",
                     ram[10'h002], ram[10'h3FD]);
        end
    endtask

    task automatic test_len_zero();
        preload_random();
        run_op(1'b0, 10'h040, 10'h050, 10'd0, 8'h00, 1'b0);
        n_cmp++;
        if (cs_count != 0 || done_cycle != 1 || done_count != 1) begin
            n_err++;
            $display("FAIL len0: cs_cycles %0d done cycle %0d count %0d, required 0/1/1",
                     cs_count, done_cycle, done_count);
        end
        run_op(1'b0, 10'h100, 10'h200, 10'd3, 8'h00, 1'b1);
        n_cmp++;
        if (done_count != 1 || done_cycle != 10 || proto_err != 0) begin
            n_err++;
            $display("FAIL busy_start: done count %0d cycle %0d bad %0d, required 1/10/0",
                     done_count, done_cycle, proto_err);
        end
        n_cmp++;
        if (mem_diffs() != 0) begin
            n_err++;
            $display("FAIL busy_start_mem: %0d words differ, required 0", mem_diffs());
        end
    endtask

    task automatic test_overlap();
        preload_random();
        ram[10'h020] <= 8'h11; ram[10'h021] <= 8'h22; ram[10'h022] <= 8'h33;
        @(negedge clk);
        run_op(1'b0, 10'h020, 10'h021, 10'd2, 8'h00, 1'b0);
        n_cmp++;
        if (ram[10'h020] !== 8'h11 || ram[10'h021] !== 8'h11 || ram[10'h022] !== 8'h11) begin
            n_err++;
            $display("FAIL overlap: %h %h %h, required 11 11 11",
                     ram[10'h020], ram[10'h021], ram[10'h022]);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] old2, old3, w0;
        int dones = 0;
        preload_random();
        w0 = ram[10'h030]; old2 = ram[10'h092]; old3 = ram[10'h093];
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src = 10'h030; dst = 10'h090; len = 10'd4;
        @(posedge clk);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_cmp++;
        if (mem_cs !== 1'b1 || mem_wen !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre: cs=%b wen=%b in 2nd write cycle, required 1/1",
                     mem_cs, mem_wen);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, mem_cs, mem_wen} !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_now: busy/done/cs/wen = %b, required 0000",
                     {busy, done, mem_cs, mem_wen});
        end
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) dones++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort_nodone: %0d cycles with done/busy, required 0", dones);
        end
        n_cmp++;
        if (ram[10'h090] !== w0 || ram[10'h092] !== old2 || ram[10'h093] !== old3) begin
            n_err++;
            $display("FAIL abort_mem: %h %h %h, required %h %h %h",
                     ram[10'h090], ram[10'h092], ram[10'h093], w0, old2, old3);
        end
        run_op(1'b0, 10'h030, 10'h090, 10'd4, 8'h00, 1'b0);
        n_cmp++;
        if (done_cycle != 13 || proto_err != 0 || mem_diffs() != 0) begin
            n_err++;
            $display("FAIL abort_restart: done %0d bad %0d diffs %0d, required 13/0/0",
                     done_cycle, proto_err, mem_diffs());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            logic         m;
            logic [A-1:0] s, d, l;
            logic [W-1:0] f;
            int           exp_done;
            m = 1'($urandom);
            s = A'($urandom);
            d = A'($urandom);
            l = A'($urandom_range(1, 24));
            f = W'($urandom);
            exp_done = m ? int'(l) + 1 : 3 * int'(l) + 1;
            preload_random();
            run_op(m, s, d, l, f, 1'($urandom));
            n_cmp++;
            if (proto_err != 0) begin
                n_err++;
                $display("FAIL rand%0d_bus: %0d bad cycles (first %0d), required 0",
                         t, proto_err, first_bad);
            end
            n_cmp++;
            if (done_cycle != exp_done || done_count != 1) begin
                n_err++;
                $display("FAIL rand%0d_done: cycle %0d count %0d, required %0d/1",
                         t, done_cycle, done_count, exp_done);
            end
            n_cmp++;
            if (mem_diffs() != 0) begin
                n_err++;
                $display("FAIL rand%0d_mem: %0d words differ, required 0", t, mem_diffs());
            end
        end
    endtask

    initial begin
        start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
        reset = 1'b0;
        test_reset();
        test_copy_basic();
        test_fill_wrap();
        test_len_zero();
        test_overlap();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
